// File: rtl/regfile_wb_sched_pkg.sv
// Shared definitions for the register-file write-back scheduler.
//   REG_ADDR_W / XLEN / NUM_REGS : register-file geometry
//   CNT_W                        : width of the starvation counter
//   sched_state_t                : starvation FSM state encoding
package regfile_wb_sched_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-result scoreboard for long-latency writes.
//   clk, rst          : clock, synchronous active-high reset
//   set_en, set_addr  : mark a register as pending
//   clr_en, clr_addr  : retire a pending register (set wins on collision)
//   rd*_addr, rd*_busy: three combinational read ports
// Bit 0 is held at 0 so x0 never reads busy and marks of x0 vanish.
module regfile_scoreboard
    import regfile_wb_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rd0_addr,
    input  logic [REG_ADDR_W-1:0] rd1_addr,
    input  logic [REG_ADDR_W-1:0] rd2_addr,
    output logic                  rd0_busy,
    output logic                  rd1_busy,
    output logic                  rd2_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        // set applied after clear so a same-edge mark keeps the bit high
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign rd0_busy = busy_q[rd0_addr];
    assign rd1_busy = busy_q[rd1_addr];
    assign rd2_busy = busy_q[rd2_addr];

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the single register-file write port.
//   A (a_*)      : pipeline writeback, fixed priority, never stalled
//   B (b_*)      : long-latency result, valid/ready, b_ready = !a_valid
//   mark_*       : issue of a long-latency op, sets its rd pending
//   chk_*/ *_busy: hazard checks against the pending scoreboard
//   rd_*_out     : registered write port, one cycle after accept
//   freeze_out   : registered, high in FORCE to let B through
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | B not being starved
// WAIT  | B has lost arbitration cnt consecutive cycles
// FORCE | pipeline frozen until B is accepted
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  logic [XLEN-1:0]       a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  logic [XLEN-1:0]       b_data,
    input  logic                  mark_valid,
    input  logic [REG_ADDR_W-1:0] mark_addr,
    input  logic [REG_ADDR_W-1:0] chk_rs1_addr,
    input  logic [REG_ADDR_W-1:0] chk_rs2_addr,
    input  logic [REG_ADDR_W-1:0] chk_rd_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_busy,
    output logic                  rd_we_out,
    output logic [REG_ADDR_W-1:0] rd_addr_out,
    output logic [XLEN-1:0]       rd_data_out,
    output logic                  freeze_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

    sched_state_t          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic                  freeze_q, freeze_d;
    logic                  accept_b;

    assign b_ready  = !a_valid;
    assign accept_b = b_valid && !a_valid;

    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (a_valid) begin
            addr_d = a_addr;
            data_d = a_data;
            we_d   = (a_addr != '0);
        end else if (b_valid) begin
            addr_d = b_addr;
            data_d = b_data;
            we_d   = (b_addr != '0);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (b_valid && a_valid) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT: begin
                // a dropped b_valid is a protocol violation; just recover
                if (accept_b || !b_valid) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = FORCE;
                end
            end
            FORCE: begin
                if (accept_b || !b_valid) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        freeze_d = (state_d == FORCE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            freeze_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            freeze_q <= freeze_d;
        end
    end

    assign rd_we_out   = we_q;
    assign rd_addr_out = addr_q;
    assign rd_data_out = data_q;
    assign freeze_out  = freeze_q;

    // cleared at the edge that loads the write port, so the bit reads idle
    // in the write cycle and relies on the register file's bypass
    regfile_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (mark_valid),
        .set_addr (mark_addr),
        .clr_en   (accept_b),
        .clr_addr (b_addr),
        .rd0_addr (chk_rs1_addr),
        .rd1_addr (chk_rs2_addr),
        .rd2_addr (chk_rd_addr),
        .rd0_busy (rs1_busy),
        .rd1_busy (rs2_busy),
        .rd2_busy (rd_busy)
    );

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Write-back scheduler for the single write port of the 32x32 integer register file.
- Shares that port between two requesters: the in-order pipeline writeback (A, never back-pressured) and a long-latency unit such as a divider or load unit (B, valid/ready).
- Keeps a per-register scoreboard of pending B results, so issue logic can stall on RAW and WAW hazards.
- Prevents B starvation by freezing the pipeline for one write slot.

Parameters:
- STARVE_MAX, default 4, range 2..15: consecutive cycles B may lose arbitration before the pipeline is frozen.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- a_valid  in  1  Pipeline writeback request.
- a_addr  in  5  Pipeline rd.
- a_data  in  32  Pipeline result.
- b_valid  in  1  Long-latency result valid.
- b_ready  out  1  B accepted this cycle. Combinational, equal to !a_valid.
- b_addr  in  5  Long-latency rd.
- b_data  in  32  Long-latency result.
- mark_valid  in  1  Issue of a long-latency instruction.
- mark_addr  in  5  Its rd.
- chk_rs1_addr  in  5  Operand 1 address to check.
- chk_rs2_addr  in  5  Operand 2 address to check.
- chk_rd_addr  in  5  Destination address to check.
- rs1_busy  out  1  Combinational: operand 1 pending.
- rs2_busy  out  1  Combinational: operand 2 pending.
- rd_busy  out  1  Combinational: destination pending (WAW).
- rd_we_out  out  1  Register file write enable (registered).
- rd_addr_out  out  5  Register file write address (registered).
- rd_data_out  out  32  Register file write data (registered).
- freeze_out  out  1  Registered; high only in FORCE. The pipeline must hold a_valid=0 while it is high.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, starve counter=0, scoreboard=0.
  - rd_we_out=0, rd_addr_out=0, rd_data_out=0, freeze_out=0.
  - Reset during WAIT or FORCE abandons the pending B request. B must re-present it; the scoreboard is cleared.
- Arbitration and write latency:
  - A has fixed priority.
  - Accept_A = a_valid. Accept_B = b_valid && !a_valid.
  - One cycle from accept to the write port. The next edge loads rd_we_out=1, rd_addr_out, and rd_data_out from the winner.
  - With no accept, rd_we_out=0 and addr/data hold their previous values.
- x0 handling:
  - An accepted write with addr 0 completes the handshake but drives rd_we_out=0.
  - mark with addr 0 is ignored.
  - Busy outputs for addr 0 are always 0.
- Scoreboard (32 bits, bit 0 tied to 0):
  - mark_valid sets bit[mark_addr] at the edge.
  - A B write clears bit[b_addr] at the edge where rd_we_out rises for it. The bit reads busy during the accept cycle and idle during the write cycle. This relies on the register file's write-to-read bypass.
  - Set and clear of the same address at the same edge: set wins.
  - Mark of an already-busy address: bit stays 1. Issue logic prevents this via rd_busy.
  - An A write never touches the scoreboard.
  - busy outputs = bit[chk_*_addr], with no forwarding of same-cycle marks.
- Starvation FSM (2-bit state, counter width 4):
  - IDLE:
    - If b_valid && a_valid: go to WAIT, cnt=1.
    - Otherwise stay. An accepted B stays IDLE.
  - WAIT:
    - B accepted, or b_valid drops (protocol violation): go to IDLE, cnt=0.
    - Otherwise cnt+1. When cnt==STARVE_MAX-1 and B still loses: go to FORCE.
  - FORCE:
    - freeze_out=1.
    - B accepted: go to IDLE, cnt=0.
    - If a_valid is asserted anyway, A still wins and the state stays FORCE.
- Maximum B wait with a compliant pipeline is STARVE_MAX+1 cycles.

Decomposition:
- Shared package constants: REG_ADDR_W=5, XLEN=32, NUM_REGS=32.
- Shared package enum: sched_state_t {IDLE, WAIT, FORCE}.
- Natural sub-module: regfile_scoreboard, containing the 32-bit set/clear vector and three read ports. Arbiter and FSM stay in the top.

Test Plan:
- Reset, then A writes x5=0xDEADBEEF -> next cycle rd_we_out=1, rd_addr_out=5, rd_data_out=0xDEADBEEF; busy outputs all 0.
- mark x7, then 3 cycles later B writes x7=0x12345678 with a_valid=0 -> rs1_busy(chk=7)=1 from the cycle after mark through the accept cycle, then 0 in the write cycle where rd_we_out=1, addr=7.
- a_valid held high with b_valid high, STARVE_MAX=4 -> b_ready=0, freeze_out rises 4 cycles after b_valid. Bench drops a_valid -> B accepted, written next cycle, freeze_out=0, state IDLE.
- B write to x0 with data 0xFFFFFFFF -> b_ready=1, rd_we_out stays 0. mark x0 -> chk x0 busy=0.
- Same edge: mark x9 and B write to x9 accepted earlier -> bit 9 remains 1 after the edge; rd_busy(chk=9)=1.
- rst asserted in FORCE with bit 3 set -> next cycle freeze_out=0, rd_we_out=0, busy for x3=0.
